alu_result_stage: RTL and testbench

Pipeline register between the 32-bit ALU and the memory stage. It captures the ALU result word plus the carryout and overflow flags, derives a zero flag, and hands them downstream over a valid/ready handshake. It absorbs one cycle of downstream back-pressure with a two-entry skid buffer, so `in_ready` is a registered signal and never combinationally depends on `out_ready`.

---
 rtl/alu_stage_pkg.sv | 33 +++
 rtl/alu_skid_buffer.sv | 95 +++++++++
 rtl/alu_result_stage.sv | 70 +++++++
 tb/tb_alu_result_stage.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_stage_pkg.sv
// Shared types for the ALU result stage: entry layout, buffer states and
// the helper that derives the zero flag at capture time.
package alu_stage_pkg;

  localparam int ALU_WIDTH = 32;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] result;
    logic                 carryout;
    logic                 overflow;
    logic                 zero;
  } alu_entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } alu_state_t;

  function automatic alu_entry_t make_entry(
    input logic [ALU_WIDTH-1:0] result,
    input logic                 carryout,
    input logic                 overflow
  );
    alu_entry_t e;
    e.result   = result;
    e.carryout = carryout;
    e.overflow = overflow;
    e.zero     = (result == '0);
    return e;
  endfunction

endpackage

// File: rtl/alu_skid_buffer.sv
// Generic two-entry valid/ready skid buffer carrying alu_entry_t.
// in_ready is a flop so it never depends combinationally on out_ready.
module alu_skid_buffer
  import alu_stage_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  alu_entry_t in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output alu_entry_t out_data
);

  localparam logic [1:0] ST_EMPTY = EMPTY;
  localparam logic [1:0] ST_ONE   = ONE;
  localparam logic [1:0] ST_FULL  = FULL;

  logic [1:0] state;
  logic [1:0] next_state;
  logic       in_ready_q;
  alu_entry_t main_q;
  alu_entry_t skid_q;
  logic       in_xfer;
  logic       out_xfer;
  logic       load_main;
  logic       load_skid;
  logic       main_from_skid;

  assign out_valid = (state != ST_EMPTY);
  assign in_ready  = in_ready_q;
  assign out_data  = main_q;
  assign in_xfer   = in_valid && in_ready_q;
  assign out_xfer  = out_valid && out_ready;

  // Flush overrides any transfer; the held data is left as don't-care.
  always_comb begin
    next_state     = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      next_state = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_xfer) begin
            next_state = ST_ONE;
            load_main  = 1'b1;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            load_main = 1'b1;
          end else if (in_xfer) begin
            next_state = ST_FULL;
            load_skid  = 1'b1;
          end else if (out_xfer) begin
            next_state = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_xfer) begin
            next_state     = ST_ONE;
            main_from_skid = 1'b1;
          end
        end
        default: next_state = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state      <= next_state;
      in_ready_q <= (next_state != ST_FULL);
      if (load_main) begin
        main_q <= in_data;
      end else if (main_from_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Pipeline register between the ALU and memory stage. Optional sticky
// overflow trap is enabled by defining ALU_STAGE_OVF_TRAP_EN.
module alu_result_stage
  import alu_stage_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_carryout,
  input  logic             in_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carryout,
  output logic             out_overflow,
  output logic             out_zero,
  output logic             ovf_trap,
  input  logic             trap_clear
);

  alu_entry_t in_entry;
  alu_entry_t out_entry;

  assign in_entry = make_entry(in_result, in_carryout, in_overflow);

  alu_skid_buffer u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_entry)
  );

  assign out_result   = out_entry.result;
  assign out_carryout = out_entry.carryout;
  assign out_overflow = out_entry.overflow;
  assign out_zero     = out_entry.zero;

`ifdef ALU_STAGE_OVF_TRAP_EN
  logic trap_q;

  // Setting on an overflowing hand-off beats a coincident clear; flush is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trap_q <= 1'b0;
    end else if (out_valid && out_ready && out_entry.overflow) begin
      trap_q <= 1'b1;
    end else if (trap_clear) begin
      trap_q <= 1'b0;
    end
  end

  assign ovf_trap = trap_q;
`else
  logic unused_trap_clear;

  assign unused_trap_clear = trap_clear;
  assign ovf_trap          = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: queue-based reference model
// compared every cycle, plus directed vectors with literal expectations.
module tb_alu_result_stage;

`ifdef ALU_STAGE_OVF_TRAP_EN
  localparam logic TRAP_ON = 1'b1;
`else
  localparam logic TRAP_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_result = '0;
  logic        in_carryout = 1'b0;
  logic        in_overflow = 1'b0;
  logic        out_ready = 1'b0;
  logic        trap_clear = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_result;
  logic        out_carryout;
  logic        out_overflow;
  logic        out_zero;
  logic        ovf_trap;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] r;
    logic        c;
    logic        o;
  } item_t;

  item_t q[$];
  logic  m_ready = 1'b1;
  logic  m_trap = 1'b0;

  alu_result_stage dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_carryout  (in_carryout),
    .in_overflow  (in_overflow),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_carryout (out_carryout),
    .out_overflow (out_overflow),
    .out_zero     (out_zero),
    .ovf_trap     (ovf_trap),
    .trap_clear   (trap_clear)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of at most two accepted items.
  always @(posedge clk or posedge reset) begin
    bit    acc_in;
    bit    acc_out;
    item_t it;
    if (reset) begin
      q.delete();
      m_ready = 1'b1;
      m_trap  = 1'b0;
    end else begin
      acc_in  = in_valid && m_ready;
      acc_out = (q.size() > 0) && out_ready;
      if (TRAP_ON) begin
        if (acc_out && q[0].o) m_trap = 1'b1;
        else if (trap_clear) m_trap = 1'b0;
      end
      if (flush) begin
        q.delete();
      end else begin
        if (acc_out) void'(q.pop_front());
        if (acc_in) begin
          it.r = in_result;
          it.c = in_carryout;
          it.o = in_overflow;
          q.push_back(it);
        end
      end
      m_ready = (q.size() < 2);
    end
  end

  always @(posedge clk) begin
    #1;
    check_output("cyc_out_valid", 32'(out_valid), 32'(q.size() > 0));
    check_output("cyc_in_ready", 32'(in_ready), 32'(m_ready));
    check_output("cyc_ovf_trap", 32'(ovf_trap), 32'(m_trap));
    if (q.size() > 0) begin
      check_output("cyc_result", out_result, q[0].r);
      check_output("cyc_carry", 32'(out_carryout), 32'(q[0].c));
      check_output("cyc_overflow", 32'(out_overflow), 32'(q[0].o));
      check_output("cyc_zero", 32'(out_zero), 32'(q[0].r == 32'h0));
    end
  end

  task automatic apply_stimulus(input logic v, input logic [31:0] d, input logic c,
                                input logic o, input logic rdy, input logic fl,
                                input logic tc);
    @(negedge clk);
    in_valid    = v;
    in_result   = d;
    in_carryout = c;
    in_overflow = o;
    out_ready   = rdy;
    flush       = fl;
    trap_clear  = tc;
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_out_valid"}, 32'(out_valid), 32'h0);
    check_output({tag, "_in_ready"}, 32'(in_ready), 32'h1);
    check_output({tag, "_result"}, out_result, 32'h0);
    check_output({tag, "_carry"}, 32'(out_carryout), 32'h0);
    check_output({tag, "_overflow"}, 32'(out_overflow), 32'h0);
    check_output({tag, "_zero"}, 32'(out_zero), 32'h0);
    check_output({tag, "_trap"}, 32'(ovf_trap), 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] snap_r;
    logic        snap_c;
    logic        snap_o;
    logic        snap_z;

    #12;
    check_reset_values("reset");
    @(negedge clk);
    reset = 1'b0;

    // Streaming at full rate
    apply_stimulus(1, 32'h00000001, 0, 0, 1, 0, 0);
    check_output("s1_valid", 32'(out_valid), 32'h1);
    check_output("s1_result", out_result, 32'h00000001);
    check_output("s1_zero", 32'(out_zero), 32'h0);
    apply_stimulus(1, 32'hFFFFFFFF, 1, 0, 1, 0, 0);
    check_output("s2_result", out_result, 32'hFFFFFFFF);
    check_output("s2_carry", 32'(out_carryout), 32'h1);
    check_output("s2_zero", 32'(out_zero), 32'h0);
    check_output("s2_in_ready", 32'(in_ready), 32'h1);
    apply_stimulus(1, 32'h00000000, 0, 0, 1, 0, 0);
    check_output("s3_result", out_result, 32'h00000000);
    check_output("s3_zero", 32'(out_zero), 32'h1);
    check_output("s3_in_ready", 32'(in_ready), 32'h1);
    apply_stimulus(0, 32'h0, 0, 0, 1, 0, 0);
    check_output("s4_drained", 32'(out_valid), 32'h0);

    // Back-pressure fills the skid entry
    apply_stimulus(1, 32'hA5A5A5A5, 1, 0, 0, 0, 0);
    check_output("bp1_result", out_result, 32'hA5A5A5A5);
    check_output("bp1_in_ready", 32'(in_ready), 32'h1);
    apply_stimulus(1, 32'h5A5A5A5A, 0, 0, 0, 0, 0);
    check_output("bp2_in_ready", 32'(in_ready), 32'h0);
    check_output("bp2_result", out_result, 32'hA5A5A5A5);

    snap_r = out_result;
    snap_c = out_carryout;
    snap_o = out_overflow;
    snap_z = out_zero;
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1, 32'hDEADBEEF, 0, 1, 0, 0, 0);
      check_output("hold_valid", 32'(out_valid), 32'h1);
      check_output("hold_result", out_result, snap_r);
      check_output("hold_carry", 32'(out_carryout), 32'(snap_c));
      check_output("hold_overflow", 32'(out_overflow), 32'(snap_o));
      check_output("hold_zero", 32'(out_zero), 32'(snap_z));
    end

    apply_stimulus(0, 32'h0, 0, 0, 1, 0, 0);
    check_output("bp3_result", out_result, 32'h5A5A5A5A);
    check_output("bp3_in_ready", 32'(in_ready), 32'h1);
    apply_stimulus(0, 32'h0, 0, 0, 1, 0, 0);
    check_output("bp4_drained", 32'(out_valid), 32'h0);
    check_output("bp4_in_ready", 32'(in_ready), 32'h1);

    // Flush from FULL discards the coincident input
    apply_stimulus(1, 32'h11111111, 0, 0, 0, 0, 0);
    apply_stimulus(1, 32'h22222222, 0, 0, 0, 0, 0);
    check_output("fl_full", 32'(in_ready), 32'h0);
    apply_stimulus(1, 32'h12345678, 0, 0, 0, 1, 0);
    check_output("fl_valid", 32'(out_valid), 32'h0);
    check_output("fl_in_ready", 32'(in_ready), 32'h1);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(0, 32'h0, 0, 0, 1, 0, 0);
      check_output("fl_gone", 32'(out_valid), 32'h0);
    end

    // Sticky overflow trap
    apply_stimulus(1, 32'h80000000, 1, 1, 1, 0, 0);
    check_output("tr_overflow", 32'(out_overflow), 32'h1);
    check_output("tr_before", 32'(ovf_trap), 32'h0);
    apply_stimulus(0, 32'h0, 0, 0, 1, 0, 0);
    check_output("tr_set", 32'(ovf_trap), 32'(TRAP_ON));
    apply_stimulus(0, 32'h0, 0, 0, 1, 1, 0);
    check_output("tr_flush", 32'(ovf_trap), 32'(TRAP_ON));
    apply_stimulus(1, 32'h00000007, 0, 1, 1, 0, 0);
    apply_stimulus(0, 32'h0, 0, 0, 1, 0, 1);
    check_output("tr_set_wins", 32'(ovf_trap), 32'(TRAP_ON));
    apply_stimulus(0, 32'h0, 0, 0, 1, 0, 1);
    check_output("tr_cleared", 32'(ovf_trap), 32'h0);
    apply_stimulus(0, 32'h0, 0, 0, 1, 0, 0);

    // Asynchronous reset while FULL
    apply_stimulus(1, 32'hCAFEF00D, 1, 0, 0, 0, 0);
    apply_stimulus(1, 32'hBEEF0001, 0, 0, 0, 0, 0);
    check_output("ar_full", 32'(in_ready), 32'h0);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_reset_values("async_reset");
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b0;
    apply_stimulus(1, 32'h00000003, 0, 0, 1, 0, 0);
    check_output("ar_recover", out_result, 32'h00000003);
    apply_stimulus(0, 32'h0, 0, 0, 1, 0, 0);

    repeat (2) @(posedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
